student_and16_serial: RTL
=========================

# student_and16_serial

Bit-serial 16-bit AND engine: captures two 16-bit operands on a start pulse, evaluates one bit per clock through a single `student_and` instance (LSB first), streams each result bit out with a valid/index tag, and presents the full 16-bit result with a one-cycle done pulse. It is the sequential, one-bit-per-cycle counterpart of the parallel `student_and16` datapath. It feeds serial consumers such as bit-serial ALU stages and serial debug taps, and serves as a cross-check against the parallel gate.

## Interface
- No parameters. Width is fixed at 16 and the bit index is 4 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces the IDLE state and zeroes all registers immediately.
- start  input  1  request; sampled only in IDLE.
- a  input  16  operand A, captured on an accepted start.
- b  input  16  operand B, captured on an accepted start.
- busy  output  1  high in RUN and DONE.
- bit_valid  output  1  high in RUN only.
- bit_out  output  1  AND of the current operand bit pair; valid when bit_valid=1.
- bit_idx  output  4  index (0..15) of the bit on bit_out.
- done  output  1  one-cycle pulse; out holds the new result in this cycle.
- out  output  16  last completed result; held until the next completion.

## Operation
- Internal registers: state (IDLE/RUN/DONE), sa[15:0], sb[15:0], count[3:0], acc[15:0], out[15:0].
- The only AND evaluation is one `student_and` on (sa[0], sb[0]). The built-in `&` operator must not be used for the datapath.
- IDLE: busy=0, bit_valid=0, done=0. If start=1 at an edge: sa←a, sb←b, count←0, acc←0, state←RUN. If start=0, nothing changes.
- RUN, combinational outputs: bit_valid=1, bit_out=student_and(sa[0],sb[0]), bit_idx=count.
- RUN, each edge: acc←{bit_out, acc[15:1]}; sa←sa>>1; sb←sb>>1; count←count+1.
- RUN, on the edge with count=15: out←{bit_out, acc[15:1]} and state←DONE. The 4-bit count wraps to 0 at this edge, which is harmless.
- DONE: done=1, busy=1, bit_valid=0 for exactly one cycle, then state←IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored. Operand inputs changing after capture have no effect.
- out changes only at the RUN→DONE edge or on reset. It never shows partial results.
- bit_out and bit_idx are don't-care when bit_valid=0. Drive them as 0 in IDLE and DONE.

## Timing
- Reset values: state=IDLE, busy=0, bit_valid=0, bit_out=0, bit_idx=0, done=0, out=16'h0000.
- Let edge E0 be the edge that samples start=1 in IDLE.
- Bit k (k=0..15) is presented in the cycle between edges E(k) and E(k+1).
- done is high between edges E16 and E17, giving a latency of 16 cycles from the capturing edge to done.
- The earliest next start is sampled at edge E18 (IDLE cycle after DONE). Throughput is one operation per 18 cycles with start held high.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately: no done pulse, out=0, and all outputs return to their reset values without waiting for a clock edge.
- Reset deasserted with start=1: start is sampled at the first rising edge after deassertion.

## Test plan
- Reset: assert reset with no clock edge. All outputs read 0 immediately. After release with start=0 for 5 cycles, busy stays 0.
- Pattern: a=16'hFFFF, b=16'hA5A5, one-cycle start.
  - bit_out over bit_idx 0..15 reads 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 with bit_valid=1 throughout.
  - done pulses exactly at E16; out=16'hA5A5; bit_valid=0 in the DONE cycle.
- Back-to-back: start held high, a=16'h0F0F, b=16'hFF00 first, then a=b=16'hFFFF.
  - First done shows out=16'h0F00. Second capture occurs at E18; second done shows out=16'hFFFF.
  - out stays 16'h0F00 between the two dones.
- Ignored start: during bit 5 of an op with a=16'h1234, b=16'hFFFF, pulse start with a=b=16'h0000.
  - The result is still out=16'h1234, with no extra done and no restart.
- Abort: reset asserted during bit 7 of a=b=16'hFFFF.
  - Outputs zero at once, no done, out=0.
  - A following op with a=16'h0000, b=16'hFFFF completes with out=16'h0000 and done at E16.
- Randomised: 200 random (a,b) pairs with random idle gaps.
  - Each out must equal the `student_and16` output for the same operands.
  - Each serial bitstream must match that result LSB first.

Source files
------------

// File: rtl/student_and.sv
// Single-bit AND gate used as the only evaluation element of the serial engine.
module student_and (
  input  logic x,
  input  logic y,
  output logic z
);

  // Mux form keeps the datapath free of the reduction/bitwise AND operator.
  assign z = x ? y : 1'b0;

endmodule

// File: rtl/student_and16_serial.sv
// Bit-serial 16-bit AND: captures operands on start, evaluates LSB first through one
// student_and, streams each bit with an index tag and pulses done with the full result.
module student_and16_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        bit_valid,
  output logic        bit_out,
  output logic [3:0]  bit_idx,
  output logic        done,
  output logic [15:0] out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [15:0] sa_q;
  logic [15:0] sb_q;
  logic [15:0] acc_q;
  logic [15:0] out_q;
  logic [3:0]  count_q;
  logic        busy_q;
  logic        valid_q;
  logic        done_q;
  logic        and_bit;

  student_and u_and (
    .x (sa_q[0]),
    .y (sb_q[0]),
    .z (and_bit)
  );

  // Serial outputs are forced to zero whenever no bit is being presented.
  assign bit_out   = valid_q ? and_bit : 1'b0;
  assign bit_idx   = valid_q ? count_q : 4'd0;
  assign bit_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sa_q    <= 16'h0000;
      sb_q    <= 16'h0000;
      acc_q   <= 16'h0000;
      out_q   <= 16'h0000;
      count_q <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            count_q <= 4'd0;
            acc_q   <= 16'h0000;
            state_q <= StRun;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        StRun: begin
          acc_q   <= {and_bit, acc_q[15:1]};
          sa_q    <= {1'b0, sa_q[15:1]};
          sb_q    <= {1'b0, sb_q[15:1]};
          count_q <= count_q + 4'd1;
          // Last bit: count wraps to zero here, leaving it clean for the next op.
          if (count_q == 4'd15) begin
            out_q   <= {and_bit, acc_q[15:1]};
            state_q <= StDone;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
